// File: rtl/rv_instr_encoder.sv
// Purpose: packs decoded RV32I fields (R/I/S/B/U/J) into 32-bit words and tags each with a running word address.
// Latency: word accepted at edge N is presented on out_* after edge N when the buffer was empty.
// Backpressure: 2-entry buffer; in_ready_o drops while two words are held.
// Optional feature: define RV_ENC_RANGE_CHECK_EN to flag immediates that do not fit their format.
// Ports:
//   clk_i, rstn_i (async active-low), flush_i (sync clear of buffer and address counter)
//   in_valid_i/in_ready_o + fmt_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i : input fields
//   out_valid_o/out_ready_i + out_instr_o, out_addr_o, out_err_o : encoded word from buffer head
//   err_cnt_o : saturating count of errored words pushed into the buffer
module rv_instr_encoder #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [XLEN-1:0]   imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_instr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_err_o,
  output logic [7:0]        err_cnt_o
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{instr: '0, addr: BASE, err: 1'b0};

  logic            is_shift;
  logic [XLEN-1:0] enc_instr;
  logic            fmt_err;
  logic            range_err;
  logic            enc_err;

  entry_t            head;
  entry_t            tail;
  entry_t            new_entry;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        err_cnt_q;
  logic              push;
  logic              pop;

  // Shift-immediate forms carry funct7 in the upper bits and a 5-bit shamt.
  assign is_shift = (fmt_i == FMT_I) && (opcode_i == 7'b0010011) &&
                    ((funct3_i == 3'b001) || (funct3_i == 3'b101));

  always_comb begin
    enc_instr = '0;
    fmt_err   = 1'b0;
    case (fmt_i)
      FMT_R: enc_instr = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        if (is_shift) enc_instr = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
        else          enc_instr = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_S: enc_instr = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: enc_instr = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: enc_instr = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: enc_instr = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: begin
        enc_instr = '0;
        fmt_err   = 1'b1;
      end
    endcase
  end

`ifdef RV_ENC_RANGE_CHECK_EN
  logic signed [XLEN-1:0] imm_s;
  assign imm_s = $signed(imm_i);

  // Out-of-range immediates are flagged but still packed from truncated bits.
  always_comb begin
    range_err = 1'b0;
    case (fmt_i)
      FMT_I: begin
        if (is_shift) range_err = (imm_i > 32'd31);
        else          range_err = (imm_s < -2048) || (imm_s > 2047);
      end
      FMT_S:   range_err = (imm_s < -2048) || (imm_s > 2047);
      FMT_B:   range_err = (imm_s < -4096) || (imm_s > 4094) || imm_i[0];
      FMT_U:   range_err = (imm_i[11:0] != 12'd0);
      FMT_J:   range_err = (imm_s < -1048576) || (imm_s > 1048574) || imm_i[0];
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign enc_err = fmt_err | range_err;

  assign new_entry = '{instr: enc_instr, addr: addr_q, err: enc_err};

  // Ready comes from the registered count only, so a full buffer never takes a push
  // even when the head is leaving in the same cycle.
  assign in_ready_o  = (cnt != 2'd2);
  assign out_valid_o = (cnt != 2'd0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head      <= RESET_ENTRY;
      tail      <= RESET_ENTRY;
      cnt       <= 2'd0;
      addr_q    <= BASE;
      err_cnt_q <= 8'd0;
    end else begin
      // Errors are counted at push time and survive a flush.
      if (push && enc_err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;

      if (flush_i) begin
        cnt    <= 2'd0;
        addr_q <= BASE;
      end else begin
        if (push) addr_q <= addr_q + ADDR_W'(1);
        case ({push, pop})
          // Push with pop implies exactly one word held: the new word becomes head.
          2'b11: head <= new_entry;
          2'b10: begin
            if (cnt == 2'd0) head <= new_entry;
            else             tail <= new_entry;
            cnt <= cnt + 2'd1;
          end
          2'b01: begin
            head <= tail;
            cnt  <= cnt - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_instr_o = head.instr;
  assign out_addr_o  = head.addr;
  assign out_err_o   = head.err;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
module tb_rv_instr_encoder;
  localparam int ADDR_W    = 10;
  localparam int BASE_ADDR = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0] fmt, funct3;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] imm, out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0] err_cnt;

  rv_instr_encoder #(.XLEN(32), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk_i(clk), .rstn_i(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fmt_i(fmt), .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_instr_o(out_instr), .out_addr_o(out_addr), .out_err_o(out_err),
    .err_cnt_o(err_cnt)
  );

  typedef struct {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;
  int exp_addr = BASE_ADDR;
  int exp_cnt = 0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference encoder: fields are placed by weighted shifts/masks of the immediate.
  function automatic void ref_model(input int f, input int op, input int f3, input int f7,
                                    input int d, input int s1, input int s2,
                                    input bit [31:0] im, output bit [31:0] w, output bit e);
    int si;
    bit sh;
    si = int'(im);
    sh = (f == 1) && (op == 'h13) && (f3 == 1 || f3 == 5);
    w = 0;
    e = 0;
    case (f)
      0: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
      1: if (sh) w = (f7 << 25) | ((im & 31) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
         else    w = ((im & 'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
      2: w = (((im >> 5) & 127) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) |
             ((im & 31) << 7) | op;
      3: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (s2 << 20) | (s1 << 15) |
             (f3 << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | op;
      4: w = (im & 32'hFFFF_F000) | (d << 7) | op;
      5: w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20) |
             (((im >> 12) & 255) << 12) | (d << 7) | op;
      default: begin w = 0; e = 1; end
    endcase
`ifdef RV_ENC_RANGE_CHECK_EN
    case (f)
      1: e = sh ? (im > 31) : (si < -2048 || si > 2047);
      2: e = (si < -2048 || si > 2047);
      3: e = (si < -4096 || si > 4094 || im[0]);
      4: e = (im[11:0] != 0);
      5: e = (si < -1048576 || si > 1048574 || im[0]);
      default: ;
    endcase
`else
    if (si == 0) e = e;
`endif
  endfunction

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im,
                      input logic [31:0] e_instr, input logic e_err);
    exp_t e;
    bit acc, done;
    e.instr = e_instr;
    e.addr  = exp_addr[ADDR_W-1:0];
    e.err   = e_err;
    q.push_back(e);
    exp_addr = (exp_addr + 1) % (1 << ADDR_W);
    if (e_err && exp_cnt < 255) exp_cnt++;
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      done = acc;
    end
    if (!done) begin
      checks++;
      $display("FAIL accept_timeout: word 0x%08h never accepted within 50 cycles", e_instr);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [2:0] f;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] d, s1, s2;
    logic [31:0] im;
    bit [31:0] w;
    bit e;
    f  = 3'($urandom_range(0, 7));
    op = 7'($urandom);
    f3 = 3'($urandom);
    f7 = 7'($urandom);
    d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
    if (f == 3'd1 && $urandom_range(0, 1) == 1) op = 7'h13;
    case ($urandom_range(0, 3))
      0: im = 32'($urandom_range(0, 40));
      1: im = 32'(int'($urandom_range(0, 8191)) - 4096);
      2: im = $urandom;
      default: im = 32'(int'($urandom_range(0, 2097151)) - 1048576) & ~32'd1;
    endcase
    ref_model(int'(f), int'(op), int'(f3), int'(f7), int'(d), int'(s1), int'(s2), im, w, e);
    send(f, op, f3, f7, d, s1, s2, im, w, e);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400 && q.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    check({tag, "_out_addr"}, 64'(out_addr), 64'(BASE_ADDR));
    check({tag, "_out_err"}, 64'(out_err), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
  endtask

  // Scoreboard monitor: the head word is compared whenever presented; popped on handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got instr 0x%08h addr %0d, required no word", out_instr, out_addr);
      end else begin
        check("out_instr", 64'(out_instr), 64'(q[0].instr));
        check("out_addr", 64'(out_addr), 64'(q[0].addr));
        check("out_err", 64'(out_err), 64'(q[0].err));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = 0; opcode = 0; funct3 = 0; funct7 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1, x0, 5 and its first-cycle latency
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("latency_out_instr", 64'(out_instr), 64'h0050_0093);
    check("latency_out_addr", 64'(out_addr), 64'd0);
    // Back-to-back S, B, J, U
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    // Illegal format
    send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0000_0000, 1'b1);
    check("err_cnt_after_illegal", 64'(err_cnt), 64'd1);
    // Oversized I immediate: packed from truncated bits
`ifdef RV_ENC_RANGE_CHECK_EN
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h0000_0093, 1'b1);
`else
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h0000_0093, 1'b0);
`endif
    wait_drain();
    check("err_cnt_directed", 64'(err_cnt), 64'(exp_cnt));

    // Backpressure: two accepts fill the buffer, the third waits for release
    out_ready = 1'b0;
    fork
      begin
        send_rand();
        send_rand();
        send_rand();
      end
      begin
        repeat (4) @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Random stream with random backpressure; long enough to wrap the address
    rand_rdy = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      send_rand();
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    check("err_cnt_random", 64'(err_cnt), 64'(exp_cnt));

    // Flush with one word buffered and a simultaneous input that must be dropped
    out_ready = 1'b0;
    send_rand();
    flush = 1'b1;
    in_valid = 1'b1;
    fmt = 3'd7;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    exp_addr = BASE_ADDR;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_err_cnt", 64'(err_cnt), 64'(exp_cnt));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    wait_drain();

    // Asynchronous reset mid-stream with words held
    out_ready = 1'b0;
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0000, 1'b1);
    send(3'd7, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0000, 1'b1);
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    check("pre_reset_err_cnt", 64'(err_cnt), 64'(exp_cnt));
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset_outputs("async_reset");
    #10;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
